stream_rr_arbiter: RTL
======================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester streams; SHALL be 2..8.
REQ-002 Parameter DATA_WIDTH, default 9: width of one data word.
REQ-003 Parameter BURST_LEN, default 4: words per grant, equal to the deaggregator FETCH_WIDTH; SHALL be 1..16.
REQ-004 clk  input  1  single clock; all state is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high allows new grants; low blocks new grants only.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester words, requester i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-008 req_empty_n  input  NUM_REQ  requester i has a word available.
REQ-009 req_deq  output  NUM_REQ  one-hot pop to requester i.
REQ-010 receiver_data  output  DATA_WIDTH  word forwarded to the shared FIFO.
REQ-011 receiver_full_n  input  1  shared FIFO can accept a word.
REQ-012 receiver_enq  output  1  write strobe to the shared FIFO.
REQ-013 grant_id  output  $clog2(NUM_REQ)  current or most recent owner.
REQ-014 busy  output  1  high while in BURST.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with enable=1 and any req_empty_n bit set, the arbiter SHALL pick the first requester with req_empty_n=1, searching from (last_grant+1) mod NUM_REQ upward with wrap. At the next edge it SHALL register that requester as owner, load grant_id and last_grant, clear beat_cnt and enter BURST. Arbitration latency is 1 cycle.
REQ-017 In IDLE with enable=0 or req_empty_n all zero, the FSM SHALL stay in IDLE with no strobes.
REQ-018 In BURST, beat = req_empty_n[owner] & receiver_full_n. receiver_enq and req_deq[owner] SHALL both equal beat, combinationally, in the same cycle.
REQ-019 receiver_data SHALL equal the owner's req_data slice combinationally whenever in BURST. It SHALL be 0 in IDLE.
REQ-020 Each beat SHALL increment beat_cnt. The beat where beat_cnt==BURST_LEN-1 SHALL return the FSM to IDLE at the next edge. There is one idle bubble between bursts.
REQ-021 There is no preemption. If the owner goes empty or the receiver goes full mid-burst, the arbiter SHALL hold BURST and the count with no strobes until the beat can complete. Word groups from different requesters never interleave.
REQ-022 enable falling during BURST SHALL NOT abort the burst. It only blocks the next grant.
REQ-023 Outside BURST, req_deq SHALL be all zero. req_deq SHALL never have more than one bit set.
REQ-024 A requester that deasserts req_empty_n in the same cycle a grant would be made SHALL NOT be granted. The pick uses current-cycle inputs only.
REQ-025 beat_cnt SHALL be $clog2(BURST_LEN+1) bits wide and SHALL never exceed BURST_LEN-1.
REQ-026 busy SHALL be 1 exactly when the state is BURST.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, beat_cnt 0, grant_id 0, and last_grant NUM_REQ-1 so requester 0 has first priority. req_deq, receiver_enq, receiver_data and busy SHALL read 0 while rst_n is low.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no further strobes. After release, arbitration restarts from requester 0.
REQ-029 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-030 Package stream_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default NUM_REQ, DATA_WIDTH and BURST_LEN constants.
REQ-031 The rotating-priority search SHALL be a sub-module rr_priority_picker. It is combinational: inputs are the request vector and last_grant; outputs are valid and index.
REQ-032 The arbiter SHALL have no internal data storage, so the data path is combinational pass-through only.

Verification
REQ-033 All 4 requesters full, receiver always ready, enable=1 -> grants in order 0,1,2,3,0; each grant gives 4 consecutive enq cycles, then 1 idle cycle.
REQ-034 Only requester 2 non-empty, holding words 10..13 -> grant_id=2; receiver sees 10,11,12,13 in order; req_deq[2] pulses 4 times; no other deq.
REQ-035 Owner 1 drops req_empty_n after 2 beats for 3 cycles while requester 3 stays ready -> no strobes for 3 cycles; burst resumes for 2 more beats from requester 1; then requester 3 is granted.
REQ-036 receiver_full_n toggles randomly while data flows through async_fifo1 (DSIZE 9, ASIZE 7) -> the read side sees each requester's words in contiguous groups of 4 with no loss or duplication.
REQ-037 Reset pulsed after beat 1 of requester 3's burst -> strobes drop immediately; the first post-reset grant goes to requester 0.
REQ-038 enable=0 asserted mid-burst -> the burst completes all 4 beats; no new grant follows until enable=1.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream round-robin arbiter: FSM state encoding
// and the default sizing constants used by the interface, picker and top.
package stream_arb_pkg;

  // Default number of requester streams (legal range 2..8).
  localparam int DEF_NUM_REQ    = 4;
  // Default width of one data word.
  localparam int DEF_DATA_WIDTH = 9;
  // Default words per grant; matches the downstream deaggregator fetch width.
  localparam int DEF_BURST_LEN  = 4;

  // Arbiter FSM: IDLE looks for a new owner, BURST forwards the owner's words.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of the beat counter, able to hold 0..burst_len.
  function automatic int beat_cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Stream handshake bundle between the requester FIFOs, the arbiter and the
// shared receiver FIFO. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding FIFOs.
interface stream_rr_arbiter_if
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  // Requester side: one data word and one "not empty" flag per requester.
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_empty_n;
  logic [NUM_REQ-1:0]            req_deq;

  // Receiver side: a single write port into the shared FIFO.
  logic [DATA_WIDTH-1:0]         receiver_data;
  logic                          receiver_full_n;
  logic                          receiver_enq;

  modport master (
    input  req_data,
    input  req_empty_n,
    output req_deq,
    output receiver_data,
    input  receiver_full_n,
    output receiver_enq
  );

  modport slave (
    output req_data,
    output req_empty_n,
    input  req_deq,
    input  receiver_data,
    output receiver_full_n,
    input  receiver_enq
  );

endinterface

// File: rtl/stream_rr_arbiter_picker.sv
// Rotating-priority search: finds the first set request bit starting one
// position above the last grant and wrapping around. Purely combinational.
module rr_priority_picker
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Walk the candidates from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: grants one requester at a time for a fixed
// burst of words into a shared FIFO. No data storage: the word path is a
// combinational mux from the owner's requester slice to the receiver.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  stream_rr_arbiter_if.master        bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = beat_cnt_width(BURST_LEN);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] beat_cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_index;
  logic             grant_now;
  logic             beat;
  logic             last_beat;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (bus.req_empty_n),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  // A grant is taken only from IDLE, only when enabled, and only on the
  // current cycle's request vector.
  assign grant_now = (state == IDLE) && enable && pick_valid;

  // A beat moves one word: owner has data and the receiver has room.
  assign beat      = (state == BURST) && bus.req_empty_n[grant_id] && bus.receiver_full_n;
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));

  // State register; reset drops any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable gates only new grants, never a running burst.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_now) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (beat && last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Owner, rotation pointer and beat counter; last_grant resets to the top
  // requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else if (grant_now) begin
      grant_id   <= pick_index;
      last_grant <= pick_index;
      beat_cnt   <= '0;
    end else if (beat) begin
      if (last_beat) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Strobes and data are driven only in BURST, so everything reads 0 in IDLE
  // and while reset holds the state in IDLE.
  always_comb begin
    bus.req_deq       = '0;
    bus.receiver_enq  = 1'b0;
    bus.receiver_data = '0;
    busy              = 1'b0;
    if (state == BURST) begin
      busy                  = 1'b1;
      bus.receiver_enq      = beat;
      bus.req_deq[grant_id] = beat;
      bus.receiver_data     = bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
